// File: rtl/source_read_requester.sv
// source_read_requester
//   Turns each 24-bit word address from the source address builder into one
//   fixed-length AXI4 INCR read burst. The returned read data is forwarded as
//   a 32-bit AXI Stream, with tlast generated from a local beat count. The
//   number of accepted-but-incomplete bursts is limited to MAX_OUTSTANDING.
//
// Ports
//   aclk, aresetn          clock, synchronous active-low reset
//   s_axis_t*              word-address stream in (tdata = 24-bit word address)
//   m_axi_ar*              AXI4 read address channel (INCR, 4-byte beats)
//   m_axi_r*               AXI4 read data channel
//   m_axis_t*              read data stream out, tlast on local burst boundary
//   busy                   AR pending or bursts outstanding
//   read_error             sticky: a beat came back with rresp != 0
//   framing_error          sticky: rlast disagreed with the local beat count
module source_read_requester #(
  parameter int unsigned BURST_LEN       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_WIDTH      = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [23:0]           s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  read_error,
  output logic                  framing_error
);

  localparam int unsigned BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [23:0] LOW_MASK = 24'(BURST_LEN - 1);

  typedef enum logic {
    AR_IDLE,
    AR_PEND
  } ar_state_t;

  ar_state_t             ar_state;
  logic                  active;       // low only in the reset cycle(s)
  logic [3:0]            outstanding;
  logic [BEAT_W-1:0]     beat_cnt;

  logic                  out_valid;
  logic [31:0]           out_data;
  logic                  out_last;
  logic                  skid_valid;
  logic [31:0]           skid_data;
  logic                  skid_last;
  logic                  rready_q;

  logic                  s_hs;
  logic                  r_hs;
  logic                  terminal;
  logic                  burst_done;
  logic                  out_ready;
  logic                  skid_valid_n;
  logic [23:0]           aligned_word;

  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = (ar_state == AR_PEND);
  assign m_axi_rready  = rready_q;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_data;
  assign m_axis_tlast  = out_last;

  assign s_axis_tready = active && (ar_state == AR_IDLE) &&
                         (outstanding < 4'(MAX_OUTSTANDING));
  assign busy          = (ar_state == AR_PEND) || (outstanding != '0);

  assign s_hs       = s_axis_tvalid && s_axis_tready;
  assign r_hs       = m_axi_rvalid && rready_q;
  assign terminal   = (beat_cnt == BEAT_W'(BURST_LEN - 1));
  // Stray beats after a reset must not wrap the counter below zero.
  assign burst_done = r_hs && terminal && (outstanding != '0);
  assign out_ready  = m_axis_tready || !out_valid;

  // Clearing the low bits keeps every burst inside one aligned block, so it
  // can never straddle a 4 KB boundary.
  assign aligned_word = s_axis_tdata & ~LOW_MASK;

  // rready is registered, so it must already reflect next cycle's skid state.
  always_comb begin
    skid_valid_n = skid_valid;
    if (out_ready)
      skid_valid_n = 1'b0;
    else if (r_hs)
      skid_valid_n = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ar_state      <= AR_IDLE;
      active        <= 1'b0;
      m_axi_araddr  <= '0;
      outstanding   <= '0;
      beat_cnt      <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      skid_valid    <= 1'b0;
      skid_data     <= '0;
      skid_last     <= 1'b0;
      rready_q      <= 1'b0;
      read_error    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      active   <= 1'b1;
      rready_q <= !skid_valid_n;

      case (ar_state)
        AR_IDLE: begin
          if (s_hs) begin
            m_axi_araddr <= ADDR_WIDTH'({aligned_word, 2'b00});
            ar_state     <= AR_PEND;
          end
        end
        AR_PEND: begin
          if (m_axi_arready)
            ar_state <= AR_IDLE;
        end
        default: ar_state <= AR_IDLE;
      endcase

      case ({s_hs, burst_done})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase

      if (r_hs) begin
        beat_cnt <= terminal ? '0 : beat_cnt + 1'b1;
        if (terminal != m_axi_rlast)
          framing_error <= 1'b1;
        if (m_axi_rresp != 2'b00)
          read_error <= 1'b1;
      end

      skid_valid <= skid_valid_n;
      if (out_ready) begin
        if (skid_valid) begin
          out_valid <= 1'b1;
          out_data  <= skid_data;
          out_last  <= skid_last;
        end else if (r_hs) begin
          out_valid <= 1'b1;
          out_data  <= m_axi_rdata;
          out_last  <= terminal;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (r_hs) begin
        skid_data <= m_axi_rdata;
        skid_last <= terminal;
      end
    end
  end

endmodule

// File: tb/tb_source_read_requester.sv
// Directed bench for source_read_requester (BURST_LEN=16, MAX_OUTSTANDING=4).
module tb_source_read_requester;

  logic        aclk;
  logic        aresetn;
  logic [23:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        busy;
  logic        read_error;
  logic        framing_error;

  int          checks;
  int          failures;
  logic        rand_ready;
  logic [32:0] q[$];

  source_read_requester #(
    .BURST_LEN(16),
    .MAX_OUTSTANDING(4),
    .ADDR_WIDTH(32)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .busy(busy),
    .read_error(read_error),
    .framing_error(framing_error)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Output sink: ready is either held high or toggled randomly.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Inputs only change at posedge+1, so the negedge sees what the next
  // posedge will sample.
  initial begin
    forever begin
      @(negedge aclk);
      if (m_axis_tvalid && m_axis_tready)
        q.push_back({m_axis_tlast, m_axis_tdata});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    repeat (3) step();
  endtask

  task automatic release_reset();
    aresetn = 1'b1;
    step();
  endtask

  task automatic issue_addr(input logic [23:0] a);
    logic hs;
    int unsigned n;
    s_axis_tdata  = a;
    s_axis_tvalid = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 64) begin
      hs = s_axis_tready;
      step();
      n++;
    end
    s_axis_tvalid = 1'b0;
    if (!hs) begin
      checks++;
      failures++;
      $error("FAIL s_axis_timeout observed=0 expected=1");
    end
  endtask

  task automatic wait_ar();
    logic hs;
    int unsigned n;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 64) begin
      hs = m_axi_arvalid && m_axi_arready;
      step();
      n++;
    end
    if (!hs) begin
      checks++;
      failures++;
      $error("FAIL ar_timeout observed=0 expected=1");
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l, input logic [1:0] r);
    logic hs;
    int unsigned n;
    m_axi_rdata  = d;
    m_axi_rlast  = l;
    m_axi_rresp  = r;
    m_axi_rvalid = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 64) begin
      hs = m_axi_rready;
      step();
      n++;
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rresp  = 2'b00;
    if (!hs) begin
      checks++;
      failures++;
      $error("FAIL r_timeout observed=0 expected=1");
    end
  endtask

  task automatic drain(input string tag, input int unsigned n);
    int unsigned k;
    k = 0;
    while (q.size() < n && k < 400) begin
      step();
      k++;
    end
    step();
    chk(tag, 64'(q.size()), 64'(n));
  endtask

  initial begin
    logic [32:0] exp;
    int unsigned acc;
    int unsigned ars;

    checks        = 0;
    failures      = 0;
    rand_ready    = 1'b0;
    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    m_axi_rvalid  = 1'b0;

    // ---- Reset state
    do_reset();
    chk("rst_s_tready", 64'(s_axis_tready), 64'(0));
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'(0));
    chk("rst_rready", 64'(m_axi_rready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    release_reset();
    chk("post_rst_rready", 64'(m_axi_rready), 64'(1));
    chk("post_rst_s_tready", 64'(s_axis_tready), 64'(1));

    // ---- 1: single burst at word address 0x123
    issue_addr(24'h000123);
    chk("t1_arvalid", 64'(m_axi_arvalid), 64'(1));
    chk("t1_araddr", 64'(m_axi_araddr), 64'h480);
    chk("t1_arlen", 64'(m_axi_arlen), 64'h0F);
    chk("t1_arsize", 64'(m_axi_arsize), 64'h2);
    chk("t1_arburst", 64'(m_axi_arburst), 64'h1);
    chk("t1_s_tready_blocked", 64'(s_axis_tready), 64'(0));
    step();
    chk("t1_arvalid_held", 64'(m_axi_arvalid), 64'(1));
    chk("t1_araddr_stable", 64'(m_axi_araddr), 64'h480);
    m_axi_arready = 1'b1;
    wait_ar();
    chk("t1_arvalid_drop", 64'(m_axi_arvalid), 64'(0));
    chk("t1_busy_outstanding", 64'(busy), 64'(1));
    q.delete();
    for (int unsigned i = 0; i < 16; i++) begin
      send_beat(32'h1000 + 32'(i), i == 15, 2'b00);
      if (i == 14) chk("t1_busy_before_last", 64'(busy), 64'(1));
    end
    chk("t1_busy_after_last", 64'(busy), 64'(0));
    drain("t1_count", 16);
    for (int unsigned i = 0; i < 16; i++) begin
      exp = {i == 15, 32'h1000 + 32'(i)};
      chk("t1_beat", 64'(q[i]), 64'(exp));
    end

    // ---- 2: outstanding limit
    s_axis_tdata  = 24'h000200;
    s_axis_tvalid = 1'b1;
    acc = 0;
    ars = 0;
    for (int unsigned i = 0; i < 12; i++) begin
      if (s_axis_tvalid && s_axis_tready) acc++;
      if (m_axi_arvalid && m_axi_arready) ars++;
      step();
    end
    chk("t2_accepted", 64'(acc), 64'(4));
    chk("t2_ar_issued", 64'(ars), 64'(4));
    chk("t2_s_tready_full", 64'(s_axis_tready), 64'(0));
    s_axis_tvalid = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      send_beat(32'h2000 + 32'(i), i == 15, 2'b00);
      if (i == 14) chk("t2_still_full", 64'(s_axis_tready), 64'(0));
    end
    chk("t2_reenabled", 64'(s_axis_tready), 64'(1));
    chk("t2_busy_remaining", 64'(busy), 64'(1));

    do_reset();
    release_reset();
    q.delete();

    // ---- 3: random output back-pressure over 8 bursts
    rand_ready = 1'b1;
    for (int unsigned b = 0; b < 8; b++) begin
      issue_addr(24'(b * 16));
      wait_ar();
      for (int unsigned i = 0; i < 16; i++)
        send_beat(32'h3000_0000 + 32'(b * 16 + i), i == 15, 2'b00);
    end
    rand_ready = 1'b0;
    drain("t3_count", 128);
    for (int unsigned i = 0; i < 128; i++) begin
      exp = {(i % 16) == 15, 32'h3000_0000 + 32'(i)};
      chk("t3_beat", 64'(q[i]), 64'(exp));
    end
    chk("t3_framing", 64'(framing_error), 64'(0));
    q.delete();

    // ---- 4: error response on beat 3
    issue_addr(24'h000400);
    wait_ar();
    for (int unsigned i = 0; i < 16; i++) begin
      send_beat(32'h4000 + 32'(i), i == 15, (i == 3) ? 2'b10 : 2'b00);
      if (i == 2) chk("t4_rderr_before", 64'(read_error), 64'(0));
      if (i == 3) chk("t4_rderr_set", 64'(read_error), 64'(1));
    end
    repeat (5) step();
    chk("t4_rderr_held", 64'(read_error), 64'(1));
    drain("t4_count", 16);
    exp = {1'b0, 32'h4003};
    chk("t4_beat3_delivered", 64'(q[3]), 64'(exp));
    chk("t4_framing", 64'(framing_error), 64'(0));
    q.delete();

    // ---- 5: early rlast on beat 7
    issue_addr(24'h000500);
    wait_ar();
    for (int unsigned i = 0; i < 16; i++) begin
      send_beat(32'h5000 + 32'(i), (i == 7) || (i == 15), 2'b00);
      if (i == 6) chk("t5_frm_before", 64'(framing_error), 64'(0));
      if (i == 7) chk("t5_frm_set", 64'(framing_error), 64'(1));
    end
    drain("t5_count", 16);
    for (int unsigned i = 0; i < 16; i++)
      chk("t5_tlast", 64'(q[i][32]), 64'(i == 15));
    chk("t5_busy", 64'(busy), 64'(0));
    q.delete();

    // ---- 6: reset mid-burst with two bursts outstanding
    issue_addr(24'h000600);
    wait_ar();
    issue_addr(24'h000610);
    wait_ar();
    for (int unsigned i = 0; i < 5; i++)
      send_beat(32'h6000 + 32'(i), 1'b0, 2'b00);
    aresetn = 1'b0;
    step();
    chk("t6_s_tready", 64'(s_axis_tready), 64'(0));
    chk("t6_arvalid", 64'(m_axi_arvalid), 64'(0));
    chk("t6_araddr", 64'(m_axi_araddr), 64'(0));
    chk("t6_rready", 64'(m_axi_rready), 64'(0));
    chk("t6_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("t6_tdata", 64'(m_axis_tdata), 64'(0));
    chk("t6_tlast", 64'(m_axis_tlast), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_rderr", 64'(read_error), 64'(0));
    chk("t6_frmerr", 64'(framing_error), 64'(0));
    step();
    release_reset();
    chk("t6_post_rready", 64'(m_axi_rready), 64'(1));
    chk("t6_post_s_tready", 64'(s_axis_tready), 64'(1));
    q.delete();
    issue_addr(24'h000047);
    chk("t6_new_arvalid", 64'(m_axi_arvalid), 64'(1));
    chk("t6_new_araddr", 64'(m_axi_araddr), 64'h100);
    wait_ar();
    for (int unsigned i = 0; i < 16; i++)
      send_beat(32'h7000 + 32'(i), i == 15, 2'b00);
    drain("t6_count", 16);
    for (int unsigned i = 0; i < 16; i++) begin
      exp = {i == 15, 32'h7000 + 32'(i)};
      chk("t6_beat", 64'(q[i]), 64'(exp));
    end
    chk("t6_frm_clean", 64'(framing_error), 64'(0));
    chk("t6_busy_end", 64'(busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
